control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit of the 32-bit RISC datapath. It sits directly upstream of the register select/encode stage.
- Consumes the 5-bit opcode stripped from IR and the CON flip-flop.
- Steps a T-state counter through fetch and per-class execute sequences.
- Drives Gra/Grb/Grc/Rin/Rout/BAout plus all bus-source, latch-enable, memory and ALU controls.

Parameters:
- OP_W, 5, opcode width (IR[31:27]).
- STEP_W, 4, width of state encoding on `step` debug port.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state RST.
- stop  in  1  external halt request, sampled only at instruction boundary.
- con_ff  in  1  branch condition from CON FF; valid from T4 of a branch.
- opcode  in  OP_W  opcode from select/encode stage; valid from T3 (IR latched end of T2).
- run  out  1  1 while executing, 0 in RST/HALT.
- gr_sel  out  3  {Gra,Grb,Grc}; at most one bit high.
- reg_ctl  out  3  {Rin,Rout,BAout}.
- bus_src  out  8  {PCout,Zlowout,Zhighout,MDRout,Cout,HIout,LOout,InPortout}; one-hot or zero.
- latch_en  out  10  {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,CONin,OutPortin}.
- mem_ctl  out  2  {Read,Write}.
- inc_pc  out  1  ALU increments bus value into Z.
- alu_op  out  OP_W  ALU function; meaningful only when Zin=1; 0 otherwise.
- step  out  STEP_W  current state, debug.

Behaviour:
- States: RST, T0–T7, HALT. Outputs are Moore on (state, opcode); no glitch requirement beyond a single clock domain. Unlisted outputs are 0.
- Reset (async, any time, including mid-instruction): state=RST, all outputs 0, run=0. First edge with reset low moves to T0, and run=1.
- Opcodes:
  - ld=00000, ldi=00001, st=00010, add..shl=00011..01011
  - addi=01100, andi=01101, ori=01110, mul=01111, div=10000, neg=10001, not=10010
  - br=10011, jr=10100, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011
  - Undefined opcodes execute as nop.
- Fetch (all instructions):
  - T0: PCout, MARin, inc_pc, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute:
  - ALU reg–reg: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
  - addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
  - ldi: T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=add(00011); T5 Zlowout,Gra,Rin.
  - ld: as ldi T3–T4; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - st: as ldi T3–T4; T5 Zlowout,MARin; T6 Gra,Rout,MDRin (Read=0 selects bus); T7 Write.
  - mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,alu_op=opcode; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - neg/not: T3 Grb,Rout,Zin,alu_op=opcode; T4 Zlowout,Gra,Rin.
  - br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,alu_op=add; T6 Zlowout and PCin only if con_ff=1 (sampled during T6).
  - jr: T3 Gra,Rout,PCin.
  - in: T3 InPortout,Gra,Rin.
  - out: T3 Gra,Rout,OutPortin.
  - mfhi: T3 HIout,Gra,Rin.
  - mflo: T3 LOout,Gra,Rin.
  - nop: no T3; T2→T0.
  - halt: T2→HALT.
- After the last execute step the next state is T0, unless stop=1 at that edge, in which case next state is HALT.
- HALT: all outputs 0, run=0, absorbing; exits only via reset.
- Latency: nop 3 cycles; jr/in/out/mf* 4; ALU/imm/ldi 6; neg/not 5; mul/div and br 7; ld/st 8.

Decomposition:
- Shared package cpu_defs holds:
  - opcode localparams;
  - state encodings (RST=0, T0..T7=1..8, HALT=15);
  - bit-index constants for bus_src, latch_en, gr_sel, reg_ctl, mem_ctl.
- One sub-module, control_decode: purely combinational (state, opcode, con_ff) → control word.
- The top level holds the state register and next-state logic.

Test Plan:
- Reset asserted mid-T4 of add → same cycle all outputs 0, run=0, step=0. Release → next edge step=T0 with PCout=MARin=inc_pc=Zin=1.
- opcode=00011 (add) → T3 gr_sel=010,Rout; T4 gr_sel=001,Zin,alu_op=00011; T5 Zlowout,gr_sel=100,Rin. The following cycle is T0 (6 cycles total).
- opcode=00000 (ld) → T5 MARin, T6 Read+MDRin, T7 MDRout+Rin with gr_sel=100. 8 cycles; Write never 1.
- opcode=10011 (br) with con_ff=1 → T6 PCin+Zlowout. Repeat with con_ff=0 → T6 PCin=0; next state T0 both cases.
- opcode=11011 (halt) → after T2 step=15, run=0, outputs 0 for 20+ cycles; only reset recovers.
- stop=1 raised during T4 of addi → instruction completes through T5, then HALT. An undefined opcode 11111 behaves as nop (T2→T0).

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control unit.
// Holds the opcode map, the sequencer state encoding, the opcode classes,
// the bit positions inside each control group and the packed control word.
package cpu_defs;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT,
    C_BR, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_e;

  // gr_sel = {Gra,Grb,Grc}
  localparam int unsigned GR_A = 2, GR_B = 1, GR_C = 0;
  // reg_ctl = {Rin,Rout,BAout}
  localparam int unsigned RC_IN = 2, RC_OUT = 1, RC_BA = 0;
  // bus_src = {PCout,Zlowout,Zhighout,MDRout,Cout,HIout,LOout,InPortout}
  localparam int unsigned BS_PC = 7, BS_ZLO = 6, BS_ZHI = 5, BS_MDR = 4;
  localparam int unsigned BS_C = 3, BS_HI = 2, BS_LO = 1, BS_INP = 0;
  // latch_en = {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,CONin,OutPortin}
  localparam int unsigned LE_PC = 9, LE_IR = 8, LE_MAR = 7, LE_MDR = 6, LE_Y = 5;
  localparam int unsigned LE_Z = 4, LE_HI = 3, LE_LO = 2, LE_CON = 1, LE_OUTP = 0;
  // mem_ctl = {Read,Write}
  localparam int unsigned MC_RD = 1, MC_WR = 0;

  typedef struct packed {
    logic       run;
    logic [2:0] gr_sel;
    logic [2:0] reg_ctl;
    logic [7:0] bus_src;
    logic [9:0] latch_en;
    logic [1:0] mem_ctl;
    logic       inc_pc;
    logic [4:0] alu_op;
  } ctrl_t;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e c;
    if (op == OP_LD)                      c = C_LD;
    else if (op == OP_LDI)                c = C_LDI;
    else if (op == OP_ST)                 c = C_ST;
    else if (op >= OP_ADD && op <= OP_SHL) c = C_ALU;
    else if (op >= OP_ADDI && op <= OP_ORI) c = C_IMM;
    else if (op == OP_MUL || op == OP_DIV) c = C_MULDIV;
    else if (op == OP_NEG || op == OP_NOT) c = C_NEGNOT;
    else if (op == OP_BR)                 c = C_BR;
    else if (op == OP_JR)                 c = C_JR;
    else if (op == OP_IN)                 c = C_IN;
    else if (op == OP_OUT)                c = C_OUT;
    else if (op == OP_MFHI)               c = C_MFHI;
    else if (op == OP_MFLO)               c = C_MFLO;
    else if (op == OP_HALT)               c = C_HALT;
    else                                  c = C_NOP;  // nop and all undefined codes
    return c;
  endfunction

  // Final T-state of each class; the step after it is the instruction boundary.
  function automatic state_e last_step(input op_class_e c);
    state_e s;
    case (c)
      C_LD, C_ST:                     s = S_T7;
      C_ALU, C_IMM, C_LDI:            s = S_T5;
      C_MULDIV, C_BR:                 s = S_T6;
      C_NEGNOT:                       s = S_T4;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: s = S_T3;
      default:                        s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decoder.
// Ports: state (current T-state), opcode (IR[31:27]), con_ff (branch condition)
//        -> ctrl (complete control word, all zero in RST/HALT).
module control_decode
  import cpu_defs::*;
(
  input  state_e     state,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  output ctrl_t      ctrl
);

  op_class_e cls;

  always_comb begin
    cls  = op_class(opcode);
    ctrl = '0;
    ctrl.run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        ctrl.bus_src[BS_PC]   = 1'b1;
        ctrl.latch_en[LE_MAR] = 1'b1;
        ctrl.latch_en[LE_Z]   = 1'b1;
        ctrl.inc_pc           = 1'b1;
      end
      S_T1: begin
        ctrl.bus_src[BS_ZLO]  = 1'b1;
        ctrl.latch_en[LE_PC]  = 1'b1;
        ctrl.mem_ctl[MC_RD]   = 1'b1;
        ctrl.latch_en[LE_MDR] = 1'b1;
      end
      S_T2: begin
        ctrl.bus_src[BS_MDR] = 1'b1;
        ctrl.latch_en[LE_IR] = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            ctrl.gr_sel[GR_B] = 1'b1; ctrl.reg_ctl[RC_BA] = 1'b1; ctrl.latch_en[LE_Y] = 1'b1;
          end
          C_ALU, C_IMM: begin
            ctrl.gr_sel[GR_B] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_Y] = 1'b1;
          end
          C_MULDIV: begin
            ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_Y] = 1'b1;
          end
          C_NEGNOT: begin
            ctrl.gr_sel[GR_B] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1;
            ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = opcode;
          end
          C_BR: begin
            ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_CON] = 1'b1;
          end
          C_JR: begin
            ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_PC] = 1'b1;
          end
          C_IN: begin
            ctrl.bus_src[BS_INP] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          C_OUT: begin
            ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_OUTP] = 1'b1;
          end
          C_MFHI: begin
            ctrl.bus_src[BS_HI] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          C_MFLO: begin
            ctrl.bus_src[BS_LO] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            ctrl.bus_src[BS_C] = 1'b1; ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = OP_ADD;
          end
          C_ALU: begin
            ctrl.gr_sel[GR_C] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1;
            ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = opcode;
          end
          C_IMM: begin
            ctrl.bus_src[BS_C] = 1'b1; ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = opcode;
          end
          C_MULDIV: begin
            ctrl.gr_sel[GR_B] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1;
            ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = opcode;
          end
          C_NEGNOT: begin
            ctrl.bus_src[BS_ZLO] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          C_BR: begin
            ctrl.bus_src[BS_PC] = 1'b1; ctrl.latch_en[LE_Y] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_LD, C_ST: begin
            ctrl.bus_src[BS_ZLO] = 1'b1; ctrl.latch_en[LE_MAR] = 1'b1;
          end
          C_LDI, C_ALU, C_IMM: begin
            ctrl.bus_src[BS_ZLO] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          C_MULDIV: begin
            ctrl.bus_src[BS_ZLO] = 1'b1; ctrl.latch_en[LE_LO] = 1'b1;
          end
          C_BR: begin
            ctrl.bus_src[BS_C] = 1'b1; ctrl.latch_en[LE_Z] = 1'b1; ctrl.alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            ctrl.mem_ctl[MC_RD] = 1'b1; ctrl.latch_en[LE_MDR] = 1'b1;
          end
          // Read stays low so the MDR mux takes the bus value.
          C_ST: begin
            ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_OUT] = 1'b1; ctrl.latch_en[LE_MDR] = 1'b1;
          end
          C_MULDIV: begin
            ctrl.bus_src[BS_ZHI] = 1'b1; ctrl.latch_en[LE_HI] = 1'b1;
          end
          // Branch target is written back only when the condition holds.
          C_BR: begin
            ctrl.bus_src[BS_ZLO] = con_ff; ctrl.latch_en[LE_PC] = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            ctrl.bus_src[BS_MDR] = 1'b1; ctrl.gr_sel[GR_A] = 1'b1; ctrl.reg_ctl[RC_IN] = 1'b1;
          end
          C_ST: ctrl.mem_ctl[MC_WR] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: T-state register and next-state logic,
// with the control word produced by control_decode.
// Ports: clock/reset (async active-high), stop (halt at instruction boundary),
//        con_ff, opcode in; run, gr_sel, reg_ctl, bus_src, latch_en, mem_ctl,
//        inc_pc, alu_op and step (debug state) out.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned OP_W   = 5,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stop,
  input  logic              con_ff,
  input  logic [OP_W-1:0]   opcode,
  output logic              run,
  output logic [2:0]        gr_sel,
  output logic [2:0]        reg_ctl,
  output logic [7:0]        bus_src,
  output logic [9:0]        latch_en,
  output logic [1:0]        mem_ctl,
  output logic              inc_pc,
  output logic [OP_W-1:0]   alu_op,
  output logic [STEP_W-1:0] step
);

  state_e    state_q, state_d;
  op_class_e cls;
  ctrl_t     ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    cls     = op_class(opcode[4:0]);
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: begin
        // halt leaves straight from T2; other classes end at their last step,
        // where stop is honoured as the instruction boundary.
        if (state_q == S_T2 && cls == C_HALT)  state_d = S_HALT;
        else if (state_q == last_step(cls))    state_d = stop ? S_HALT : S_T0;
        else                                   state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode[4:0]),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  always_comb begin
    run      = ctrl.run;
    gr_sel   = ctrl.gr_sel;
    reg_ctl  = ctrl.reg_ctl;
    bus_src  = ctrl.bus_src;
    latch_en = ctrl.latch_en;
    mem_ctl  = ctrl.mem_ctl;
    inc_pc   = ctrl.inc_pc;
    alu_op   = OP_W'(ctrl.alu_op);
    step     = STEP_W'(state_q);
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset, stop, con_ff;
  logic [4:0] opcode;
  logic       run, inc_pc;
  logic [2:0] gr_sel, reg_ctl;
  logic [7:0] bus_src;
  logic [9:0] latch_en;
  logic [1:0] mem_ctl;
  logic [4:0] alu_op;
  logic [3:0] step;

  int checks = 0;
  int failures = 0;

  control_sequencer #(.OP_W(5), .STEP_W(4)) dut (
    .clock(clock), .reset(reset), .stop(stop), .con_ff(con_ff), .opcode(opcode),
    .run(run), .gr_sel(gr_sel), .reg_ctl(reg_ctl), .bus_src(bus_src),
    .latch_en(latch_en), .mem_ctl(mem_ctl), .inc_pc(inc_pc), .alu_op(alu_op),
    .step(step)
  );

  always #5 clock = ~clock;

  logic [32:0] obs;
  assign obs = {run, gr_sel, reg_ctl, bus_src, latch_en, mem_ctl, inc_pc, alu_op};

  // Bench-side copies of the control bit meanings.
  localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
  localparam logic [2:0] RIN = 3'b100, ROUT = 3'b010, RBA = 3'b001;
  localparam logic [7:0] B_PC = 8'h80, B_ZLO = 8'h40, B_ZHI = 8'h20, B_MDR = 8'h10;
  localparam logic [7:0] B_C = 8'h08, B_HI = 8'h04, B_LO = 8'h02, B_IN = 8'h01;
  localparam logic [9:0] L_PC = 10'h200, L_IR = 10'h100, L_MAR = 10'h080, L_MDR = 10'h040;
  localparam logic [9:0] L_Y = 10'h020, L_Z = 10'h010, L_HI = 10'h008, L_LO = 10'h004;
  localparam logic [9:0] L_CON = 10'h002, L_OUT = 10'h001;
  localparam logic [1:0] M_RD = 2'b10, M_WR = 2'b01;

  function automatic logic [32:0] cw(input logic [2:0] g, input logic [2:0] r,
                                     input logic [7:0] b, input logic [9:0] l,
                                     input logic [1:0] m, input logic inc,
                                     input logic [4:0] alu);
    return {1'b1, g, r, b, l, m, inc, alu};
  endfunction

  // Expected per-cycle control words for one whole instruction, T0 onward.
  logic [32:0] exp_q[$];
  bit          exp_halt;

  task automatic build_seq(input logic [4:0] op, input logic con);
    int o;
    o = int'(op);
    exp_q.delete();
    exp_halt = 0;
    exp_q.push_back(cw(0, 0, B_PC, L_MAR | L_Z, 0, 1, 0));
    exp_q.push_back(cw(0, 0, B_ZLO, L_PC | L_MDR, M_RD, 0, 0));
    exp_q.push_back(cw(0, 0, B_MDR, L_IR, 0, 0, 0));
    if (o <= 2) begin
      exp_q.push_back(cw(GB, RBA, 0, L_Y, 0, 0, 0));
      exp_q.push_back(cw(0, 0, B_C, L_Z, 0, 0, 5'd3));
      if (o == 1) exp_q.push_back(cw(GA, RIN, B_ZLO, 0, 0, 0, 0));
      else begin
        exp_q.push_back(cw(0, 0, B_ZLO, L_MAR, 0, 0, 0));
        if (o == 0) begin
          exp_q.push_back(cw(0, 0, 0, L_MDR, M_RD, 0, 0));
          exp_q.push_back(cw(GA, RIN, B_MDR, 0, 0, 0, 0));
        end else begin
          exp_q.push_back(cw(GA, ROUT, 0, L_MDR, 0, 0, 0));
          exp_q.push_back(cw(0, 0, 0, 0, M_WR, 0, 0));
        end
      end
    end else if (o <= 14) begin
      exp_q.push_back(cw(GB, ROUT, 0, L_Y, 0, 0, 0));
      if (o <= 11) exp_q.push_back(cw(GC, ROUT, 0, L_Z, 0, 0, op));
      else         exp_q.push_back(cw(0, 0, B_C, L_Z, 0, 0, op));
      exp_q.push_back(cw(GA, RIN, B_ZLO, 0, 0, 0, 0));
    end else if (o <= 16) begin
      exp_q.push_back(cw(GA, ROUT, 0, L_Y, 0, 0, 0));
      exp_q.push_back(cw(GB, ROUT, 0, L_Z, 0, 0, op));
      exp_q.push_back(cw(0, 0, B_ZLO, L_LO, 0, 0, 0));
      exp_q.push_back(cw(0, 0, B_ZHI, L_HI, 0, 0, 0));
    end else if (o <= 18) begin
      exp_q.push_back(cw(GB, ROUT, 0, L_Z, 0, 0, op));
      exp_q.push_back(cw(GA, RIN, B_ZLO, 0, 0, 0, 0));
    end else if (o == 19) begin
      exp_q.push_back(cw(GA, ROUT, 0, L_CON, 0, 0, 0));
      exp_q.push_back(cw(0, 0, B_PC, L_Y, 0, 0, 0));
      exp_q.push_back(cw(0, 0, B_C, L_Z, 0, 0, 5'd3));
      exp_q.push_back(con ? cw(0, 0, B_ZLO, L_PC, 0, 0, 0) : cw(0, 0, 0, 0, 0, 0, 0));
    end
    else if (o == 20) exp_q.push_back(cw(GA, ROUT, 0, L_PC, 0, 0, 0));
    else if (o == 22) exp_q.push_back(cw(GA, RIN, B_IN, 0, 0, 0, 0));
    else if (o == 23) exp_q.push_back(cw(GA, ROUT, 0, L_OUT, 0, 0, 0));
    else if (o == 24) exp_q.push_back(cw(GA, RIN, B_HI, 0, 0, 0, 0));
    else if (o == 25) exp_q.push_back(cw(GA, RIN, B_LO, 0, 0, 0, 0));
    else if (o == 27) exp_halt = 1;
  endtask

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Runs one instruction from T0; raises stop at cycle index stop_idx (if in range).
  task automatic do_instr(input logic [4:0] op, input logic con, input int stop_idx,
                          output bit halted);
    @(posedge clock); #1;
    opcode = op; con_ff = con; stop = 1'b0;
    build_seq(op, con);
    halted = exp_halt;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      chk($sformatf("op%0d_cw%0d", op, i), obs, exp_q[i]);
      chk($sformatf("op%0d_step%0d", op, i), 33'(step), 33'(i + 1));
      if (i == stop_idx) begin
        stop = 1'b1;
        halted = 1;
      end
    end
  endtask

  task automatic chk_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i % 3 == 0) opcode = 5'($urandom_range(0, 31));
      chk("halt_step", 33'(step), 33'd15);
      chk("halt_out", obs, 33'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_out", obs, 33'd0);
    chk("rst_step", 33'(step), 33'd0);
    @(negedge clock);
    reset = 1'b0;
    stop  = 1'b0;
  endtask

  bit h;
  int sidx;
  logic [4:0] rop;

  initial begin
    reset = 1'b1; stop = 1'b0; con_ff = 1'b0; opcode = 5'd0;
    #1;
    chk("init_out", obs, 33'd0);
    chk("init_step", 33'(step), 33'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // add, then reset mid-T4 and recover into T0
    do_instr(5'd3, 0, -1, h);
    @(posedge clock); #1;
    opcode = 5'd3;
    repeat (5) @(negedge clock);
    chk("midT4_step", 33'(step), 33'd5);
    reset = 1'b1;
    #1;
    chk("midrst_out", obs, 33'd0);
    chk("midrst_step", 33'(step), 33'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rel_step", 33'(step), 33'd1);
    chk("rel_out", obs, cw(0, 0, B_PC, L_MAR | L_Z, 0, 1, 0));
    do_reset();

    // directed: every class at least once
    do_instr(5'd0, 0, -1, h);   // ld
    do_instr(5'd2, 0, -1, h);   // st
    do_instr(5'd1, 0, -1, h);   // ldi
    do_instr(5'd19, 1, -1, h);  // br taken
    do_instr(5'd19, 0, -1, h);  // br not taken
    do_instr(5'd15, 0, -1, h);  // mul
    do_instr(5'd17, 0, -1, h);  // neg
    do_instr(5'd20, 0, -1, h);  // jr
    do_instr(5'd31, 0, -1, h);  // undefined -> nop
    do_instr(5'd21, 0, -1, h);  // undefined -> nop
    do_instr(5'd26, 0, -1, h);  // nop

    // stop raised in T4 of addi: completes T5 then halts
    do_instr(5'd12, 0, 4, h);
    chk_halt(4);
    do_reset();

    // halt instruction: absorbing until reset
    do_instr(5'd27, 0, -1, h);
    chk_halt(22);
    do_reset();

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      rop  = 5'($urandom_range(0, 31));
      sidx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_instr(rop, 1'($urandom_range(0, 1)), sidx, h);
      if (h) begin
        chk_halt(3);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
